// File: rtl/mrv1_pkg.sv
// Shared definitions for the mrv1 core: default geometry and width helpers.
package mrv1_pkg;

    localparam int MRV1_NUM_THREADS = 8;
    localparam int MRV1_DATA_WIDTH  = 32;
    localparam int MRV1_ITAG_WIDTH  = 3;
    localparam int MRV1_NUM_RS      = 2;
    localparam int MRV1_RF_ADDR_W   = 5;

    // A single-thread build still needs a 1-bit thread id.
    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mrv1_retire_if.sv
// FU completion bus feeding the retire stage: one tagged result per cycle.
interface mrv1_retire_if
    import mrv1_pkg::*;
#(
    parameter int NUM_THREADS_P = MRV1_NUM_THREADS,
    parameter int ITAG_WIDTH_P  = MRV1_ITAG_WIDTH,
    parameter int DATA_WIDTH_P  = MRV1_DATA_WIDTH
);
    localparam int TID_WIDTH_LP = tid_width(NUM_THREADS_P);

    logic                    exec_vld;
    logic [TID_WIDTH_LP-1:0] exec_tid;
    logic [ITAG_WIDTH_P-1:0] exec_itag;
    logic [DATA_WIDTH_P-1:0] exec_rd_data;

    modport master (output exec_vld, exec_tid, exec_itag, exec_rd_data);
    modport slave  (input  exec_vld, exec_tid, exec_itag, exec_rd_data);

endinterface

// File: rtl/mrv1_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins; one-hot and index grant.
module mrv1_rr_arb
    import mrv1_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = tid_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mrv1_retire.sv
// In-order per-thread retire/writeback: buffers tagged FU results and retires one
// complete issue-queue head per cycle, round-robin across threads.
module mrv1_retire
    import mrv1_pkg::*;
#(
    parameter int NUM_THREADS_P   = MRV1_NUM_THREADS,
    parameter int DATA_WIDTH_P    = MRV1_DATA_WIDTH,
    parameter int ITAG_WIDTH_P    = MRV1_ITAG_WIDTH,
    parameter int NUM_RS_P        = MRV1_NUM_RS,
    parameter int rf_addr_width_p = MRV1_RF_ADDR_W,
    localparam int TID_WIDTH_LP   = tid_width(NUM_THREADS_P),
    localparam int IQ_SZ_LP       = 1 << ITAG_WIDTH_P
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_i,
    mrv1_retire_if.slave                                            exec,
    input  logic [NUM_THREADS_P-1:0]                                iq_retire_rdy_i,
    input  logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]              iq_retire_itag_i,
    input  logic [NUM_THREADS_P-1:0][IQ_SZ_LP-1:0]                  iq_rd_vld_i,
    input  logic [NUM_THREADS_P-1:0][IQ_SZ_LP-1:0][rf_addr_width_p-1:0] iq_rd_addr_i,
    output logic                                                    retire_vld_o,
    output logic [TID_WIDTH_LP-1:0]                                 retire_tid_o,
    output logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]              retire_cnt_o,
    output logic                                                    rf_we_o,
    output logic [TID_WIDTH_LP-1:0]                                 rf_wr_tid_o,
    output logic [rf_addr_width_p-1:0]                              rf_wr_addr_o,
    output logic [DATA_WIDTH_P-1:0]                                 rf_wr_data_o,
    input  logic [NUM_RS_P-1:0][rf_addr_width_p-1:0]                byp_rs_addr_i,
    output logic [NUM_THREADS_P-1:0][NUM_RS_P-1:0]                  rs_byp_en_o,
    output logic [NUM_THREADS_P-1:0][NUM_RS_P-1:0][DATA_WIDTH_P-1:0] rs_byp_data_o
);

    logic [NUM_THREADS_P-1:0][IQ_SZ_LP-1:0] done_r;
    logic [DATA_WIDTH_P-1:0]                data_r [NUM_THREADS_P][IQ_SZ_LP];
    logic [TID_WIDTH_LP-1:0]                rr_ptr;

    logic [NUM_THREADS_P-1:0]   elig_p0;
    logic [NUM_THREADS_P-1:0]   gnt_oh_p0;
    logic [TID_WIDTH_LP-1:0]    gnt_tid_p0;
    logic                       gnt_vld_p0;
    logic [ITAG_WIDTH_P-1:0]    gnt_itag_p0;
    logic                       gnt_rd_vld_p0;
    logic [rf_addr_width_p-1:0] gnt_rd_addr_p0;

    // Stage p0: eligibility from registered done bits only, then thread selection.
    always_comb begin
        elig_p0 = '0;
        for (int t = 0; t < NUM_THREADS_P; t++) begin
            elig_p0[t] = iq_retire_rdy_i[t] & done_r[t][iq_retire_itag_i[t]];
        end
    end

    mrv1_rr_arb #(.N(NUM_THREADS_P)) u_thread_arb (
        .req     (elig_p0),
        .ptr     (rr_ptr),
        .gnt     (gnt_oh_p0),
        .gnt_idx (gnt_tid_p0),
        .gnt_vld (gnt_vld_p0)
    );

    assign gnt_itag_p0    = iq_retire_itag_i[gnt_tid_p0];
    assign gnt_rd_vld_p0  = iq_rd_vld_i[gnt_tid_p0][gnt_itag_p0];
    assign gnt_rd_addr_p0 = iq_rd_addr_i[gnt_tid_p0][gnt_itag_p0];

    // Result storage carries no reset; done_r alone says which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (exec.exec_vld) begin
            data_r[exec.exec_tid][exec.exec_itag] <= exec.exec_rd_data;
        end
    end

    // Stage p1: registered retire / RF write. Clearing the retiring head here keeps it
    // from retiring twice while the issue side advances its head pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_r       <= '0;
            rr_ptr       <= '0;
            retire_vld_o <= 1'b0;
            retire_tid_o <= '0;
            retire_cnt_o <= '0;
            rf_we_o      <= 1'b0;
            rf_wr_tid_o  <= '0;
            rf_wr_addr_o <= '0;
            rf_wr_data_o <= '0;
        end else begin
            if (exec.exec_vld) begin
                done_r[exec.exec_tid][exec.exec_itag] <= 1'b1;
            end
            if (gnt_vld_p0) begin
                done_r[gnt_tid_p0][gnt_itag_p0] <= 1'b0;
                rr_ptr <= (gnt_tid_p0 == TID_WIDTH_LP'(NUM_THREADS_P - 1)) ? '0
                                                                            : gnt_tid_p0 + 1'b1;
                retire_tid_o <= gnt_tid_p0;
                rf_wr_tid_o  <= gnt_tid_p0;
                rf_wr_addr_o <= gnt_rd_addr_p0;
                rf_wr_data_o <= data_r[gnt_tid_p0][gnt_itag_p0];
            end
            retire_vld_o <= gnt_vld_p0;
            for (int t = 0; t < NUM_THREADS_P; t++) begin
                retire_cnt_o[t] <= ITAG_WIDTH_P'(gnt_oh_p0[t]);
            end
            rf_we_o <= gnt_vld_p0 & gnt_rd_vld_p0 & (gnt_rd_addr_p0 != '0);
        end
    end

    // WB-stage bypass, combinational from the registered write port.
    always_comb begin
        rs_byp_en_o   = '0;
        rs_byp_data_o = '0;
        for (int t = 0; t < NUM_THREADS_P; t++) begin
            for (int k = 0; k < NUM_RS_P; k++) begin
                rs_byp_en_o[t][k]   = rf_we_o && (rf_wr_tid_o == TID_WIDTH_LP'(t))
                                      && (rf_wr_addr_o == byp_rs_addr_i[k]);
                rs_byp_data_o[t][k] = rf_wr_data_o;
            end
        end
    end

    a_no_double_complete: assert property (@(posedge clk_i) disable iff (rst_i)
        exec.exec_vld |-> !done_r[exec.exec_tid][exec.exec_itag]);

endmodule

// File: tb/tb_mrv1_retire.sv
// Self-checking bench for mrv1_retire: scoreboard of expected retires plus per-scenario timing checks.
module tb_mrv1_retire;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mrv1_retire_if #(.NUM_THREADS_P(8), .ITAG_WIDTH_P(3), .DATA_WIDTH_P(32)) exec_if ();

    logic [7:0]             iq_rdy;
    logic [7:0][2:0]        iq_itag;
    logic [7:0][7:0]        iq_rd_vld;
    logic [7:0][7:0][4:0]   iq_rd_addr;
    logic                   retire_vld;
    logic [2:0]             retire_tid;
    logic [7:0][2:0]        retire_cnt;
    logic                   rf_we;
    logic [2:0]             rf_wr_tid;
    logic [4:0]             rf_wr_addr;
    logic [31:0]            rf_wr_data;
    logic [1:0][4:0]        byp_addr;
    logic [7:0][1:0]        byp_en;
    logic [7:0][1:0][31:0]  byp_data;

    mrv1_retire #(
        .NUM_THREADS_P(8), .DATA_WIDTH_P(32), .ITAG_WIDTH_P(3), .NUM_RS_P(2), .rf_addr_width_p(5)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .exec             (exec_if),
        .iq_retire_rdy_i  (iq_rdy),
        .iq_retire_itag_i (iq_itag),
        .iq_rd_vld_i      (iq_rd_vld),
        .iq_rd_addr_i     (iq_rd_addr),
        .retire_vld_o     (retire_vld),
        .retire_tid_o     (retire_tid),
        .retire_cnt_o     (retire_cnt),
        .rf_we_o          (rf_we),
        .rf_wr_tid_o      (rf_wr_tid),
        .rf_wr_addr_o     (rf_wr_addr),
        .rf_wr_data_o     (rf_wr_data),
        .byp_rs_addr_i    (byp_addr),
        .rs_byp_en_o      (byp_en),
        .rs_byp_data_o    (byp_data)
    );

    typedef struct packed {
        logic [2:0]  tid;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Scoreboard: every retire must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0][2:0] exp_cnt;
        if (!rst && retire_vld) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: retire tid=%0d, no retire expected", retire_tid);
            end else begin
                e = sb_q.pop_front();
                if ({retire_tid, rf_wr_tid, rf_we} !== {e.tid, e.tid, e.we}) begin
                    tests_failed++;
                    $display("FAIL sb_tid_we: got tid=%0d wtid=%0d we=%0b, expected tid=%0d we=%0b",
                             retire_tid, rf_wr_tid, rf_we, e.tid, e.we);
                end
                exp_cnt = '0;
                exp_cnt[e.tid] = 3'd1;
                tests_run++;
                if (retire_cnt !== exp_cnt) begin
                    tests_failed++;
                    $display("FAIL sb_cnt: got %h, expected %h", retire_cnt, exp_cnt);
                end
                if (e.we) begin
                    tests_run++;
                    if ({rf_wr_addr, rf_wr_data} !== {e.addr, e.data}) begin
                        tests_failed++;
                        $display("FAIL sb_wdata: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 rf_wr_addr, rf_wr_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic complete(input int tid, input int itag, input logic [31:0] d);
        exec_if.exec_vld     = 1'b1;
        exec_if.exec_tid     = 3'(tid);
        exec_if.exec_itag    = 3'(itag);
        exec_if.exec_rd_data = d;
        tick();
        exec_if.exec_vld = 1'b0;
    endtask

    task automatic push_exp(input int tid, input logic we, input int addr, input logic [31:0] d);
        sb_q.push_back('{tid: 3'(tid), we: we, addr: 5'(addr), data: d});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d retires outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        tests_run++;
        if ({retire_vld, rf_we} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_vld_we: got %b, expected 00", {retire_vld, rf_we});
        end
        tests_run++;
        if (retire_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %h, expected 0", retire_cnt);
        end
        tests_run++;
        if (byp_en !== '0) begin
            tests_failed++;
            $display("FAIL reset_byp: got %h, expected 0", byp_en);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        iq_rdy[2] = 1'b1; iq_itag[2] = 3'd3;
        iq_rd_vld[2][3] = 1'b1; iq_rd_addr[2][3] = 5'd5;
        push_exp(2, 1'b1, 5, 32'hDEAD);
        complete(2, 3, 32'hDEAD);
        @(negedge clk);
        tests_run++;
        if (retire_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: retire_vld=%b one cycle after completion, expected 0", retire_vld);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if ({retire_vld, retire_tid, rf_we, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd2, 1'b1, 5'd5, 32'hDEAD}) begin
            tests_failed++;
            $display("FAIL single_retire: got vld=%b tid=%0d we=%b addr=%0d data=%h, expected 1/2/1/5/dead",
                     retire_vld, retire_tid, rf_we, rf_wr_addr, rf_wr_data);
        end
        iq_rdy[2] = 1'b0;
        drain("single");
    endtask

    task automatic test_out_of_order();
        iq_rdy[0] = 1'b1; iq_itag[0] = 3'd0;
        iq_rd_vld[0][0] = 1'b1; iq_rd_addr[0][0] = 5'd11;
        iq_rd_vld[0][1] = 1'b1; iq_rd_addr[0][1] = 5'd10;
        push_exp(0, 1'b1, 11, 32'h0000_A000);
        push_exp(0, 1'b1, 10, 32'h0000_A001);
        complete(0, 1, 32'h0000_A001);
        complete(0, 0, 32'h0000_A000);
        @(negedge clk);
        tests_run++;
        if (retire_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL ooo_early: retire_vld=%b before head complete, expected 0", retire_vld);
        end
        tick();
        iq_itag[0] = 3'd1;
        @(negedge clk);
        tests_run++;
        if ({retire_vld, rf_wr_data} !== {1'b1, 32'h0000_A000}) begin
            tests_failed++;
            $display("FAIL ooo_first: got vld=%b data=%h, expected 1/0000a000", retire_vld, rf_wr_data);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if ({retire_vld, rf_wr_data} !== {1'b1, 32'h0000_A001}) begin
            tests_failed++;
            $display("FAIL ooo_second: got vld=%b data=%h, expected 1/0000a001", retire_vld, rf_wr_data);
        end
        iq_rdy[0] = 1'b0;
        drain("ooo");
    endtask

    task automatic test_round_robin();
        logic [2:0] order [3];
        order[0] = 3'd6; order[1] = 3'd1; order[2] = 3'd4;
        // Retiring thread 4 alone leaves the pointer at 5.
        iq_rdy[4] = 1'b1; iq_itag[4] = 3'd0;
        iq_rd_vld[4][0] = 1'b1; iq_rd_addr[4][0] = 5'd12;
        push_exp(4, 1'b1, 12, 32'h4444_0000);
        complete(4, 0, 32'h4444_0000);
        drain("rr_prime");
        iq_rdy[4] = 1'b0;
        iq_itag[1] = 3'd0; iq_rd_vld[1][0] = 1'b1; iq_rd_addr[1][0] = 5'd13;
        iq_itag[4] = 3'd1; iq_rd_vld[4][1] = 1'b1; iq_rd_addr[4][1] = 5'd14;
        iq_itag[6] = 3'd0; iq_rd_vld[6][0] = 1'b1; iq_rd_addr[6][0] = 5'd15;
        complete(1, 0, 32'h1111_0001);
        complete(4, 1, 32'h4444_0001);
        complete(6, 0, 32'h6666_0001);
        push_exp(6, 1'b1, 15, 32'h6666_0001);
        push_exp(1, 1'b1, 13, 32'h1111_0001);
        push_exp(4, 1'b1, 14, 32'h4444_0001);
        iq_rdy[1] = 1'b1; iq_rdy[4] = 1'b1; iq_rdy[6] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            tests_run++;
            if ({retire_vld, retire_tid} !== {1'b1, order[i]}) begin
                tests_failed++;
                $display("FAIL rr_order%0d: got vld=%b tid=%0d, expected 1/%0d", i, retire_vld, retire_tid, order[i]);
            end
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (retire_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_idle: retire_vld=%b after all retired, expected 0", retire_vld);
        end
        iq_rdy = '0;
        drain("rr");
    endtask

    task automatic test_no_write();
        byp_addr[0] = 5'd0; byp_addr[1] = 5'd0;
        iq_rdy[5] = 1'b1; iq_itag[5] = 3'd2;
        iq_rd_vld[5][2] = 1'b1; iq_rd_addr[5][2] = 5'd0;
        push_exp(5, 1'b0, 0, 32'h0);
        complete(5, 2, 32'hBAD0_0000);
        tick();
        @(negedge clk);
        tests_run++;
        if ({retire_vld, rf_we} !== 2'b10) begin
            tests_failed++;
            $display("FAIL x0_we: got vld=%b we=%b, expected 1/0", retire_vld, rf_we);
        end
        tests_run++;
        if (byp_en !== '0) begin
            tests_failed++;
            $display("FAIL x0_byp: got %h, expected 0", byp_en);
        end
        iq_rdy[5] = 1'b0;
        iq_rdy[7] = 1'b1; iq_itag[7] = 3'd1;
        iq_rd_vld[7][1] = 1'b0; iq_rd_addr[7][1] = 5'd9;
        push_exp(7, 1'b0, 9, 32'h0);
        complete(7, 1, 32'h7777_0000);
        tick();
        @(negedge clk);
        tests_run++;
        if ({retire_vld, rf_we} !== 2'b10) begin
            tests_failed++;
            $display("FAIL nord_we: got vld=%b we=%b, expected 1/0", retire_vld, rf_we);
        end
        iq_rdy[7] = 1'b0;
        drain("nowrite");
    endtask

    task automatic test_bypass();
        logic [7:0][1:0] exp_en;
        exp_en = '0;
        exp_en[3] = 2'b01;
        byp_addr[0] = 5'd7; byp_addr[1] = 5'd9;
        iq_rdy[3] = 1'b1; iq_itag[3] = 3'd4;
        iq_rd_vld[3][4] = 1'b1; iq_rd_addr[3][4] = 5'd7;
        push_exp(3, 1'b1, 7, 32'h55);
        complete(3, 4, 32'h55);
        tick();
        @(negedge clk);
        tests_run++;
        if (byp_en !== exp_en) begin
            tests_failed++;
            $display("FAIL byp_en: got %h, expected %h", byp_en, exp_en);
        end
        tests_run++;
        if (byp_data[3][0] !== 32'h55) begin
            tests_failed++;
            $display("FAIL byp_data: got %h, expected 00000055", byp_data[3][0]);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (byp_en !== '0) begin
            tests_failed++;
            $display("FAIL byp_clear: got %h, expected 0", byp_en);
        end
        iq_rdy[3] = 1'b0;
        drain("bypass");
    endtask

    task automatic test_reset_mid();
        iq_rdy[1] = 1'b1; iq_itag[1] = 3'd5;
        iq_rd_vld[1][5] = 1'b1; iq_rd_addr[1][5] = 5'd3;
        complete(1, 5, 32'hCAFE_0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({retire_vld, rf_we} !== 2'b00) begin
                tests_failed++;
                $display("FAIL midrst_quiet%0d: got vld=%b we=%b, expected 0/0", i, retire_vld, rf_we);
            end
            tick();
        end
        push_exp(1, 1'b1, 3, 32'hCAFE_0002);
        complete(1, 5, 32'hCAFE_0002);
        iq_rdy[1] = 1'b0;
        tick();
        iq_rdy[1] = 1'b1;
        drain("midrst");
        iq_rdy[1] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exec_if.exec_vld     = 1'b0;
        exec_if.exec_tid     = '0;
        exec_if.exec_itag    = '0;
        exec_if.exec_rd_data = '0;
        iq_rdy     = '0;
        iq_itag    = '0;
        iq_rd_vld  = '0;
        iq_rd_addr = '0;
        byp_addr   = '0;
        test_reset();
        test_single();
        test_out_of_order();
        test_round_robin();
        test_no_write();
        test_bypass();
        test_reset_mid();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
